stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Four-digit BCD stopwatch (SS.hh, 00.00–99.99) that generates the 16-bit value shown on the board's four seven-segment digits. It sits directly upstream of the four-digit hex display stage: `DIGITS[15:12]` drives HEX3 and `DIGITS[3:0]` drives HEX0. The block takes active-low pushbuttons, synchronises them and edge-detects them. It runs a start/stop/lap/clear state machine and a prescaled BCD counter.

## Interface
- `TICK_DIV`, default 500000: clock cycles per count increment (50 MHz / 100 Hz = 0.01 s). Must be ≥ 2. Benches use 4.
- `CLOCK_50` input 1: single system clock; all state changes on the rising edge.
- `RESET` input 1: reset, asynchronous, active-high.
- `KEY` input 3: active-low pushbuttons, asynchronous to `CLOCK_50`.
  - `KEY[0]`: start/stop.
  - `KEY[1]`: lap.
  - `KEY[2]`: clear.
- `DIGITS` output 16: four BCD digits.
  - `[15:12]` tens of seconds, `[11:8]` seconds, `[7:4]` tenths, `[3:0]` hundredths.
  - Each digit is always in the range 0–9.
- `RUNNING` output 1: high in RUN or LAP.
- `LAP_ACTIVE` output 1: high in LAP, meaning the display is frozen.
- `OVERFLOW` output 1: sticky; set when the count wraps 99.99→00.00.

## Operation
- **Key input path.** Each KEY bit passes through a 2-FF synchroniser (`s1`, `s2`) and a history register `p`.
  - Press pulse = `p & ~s2`, one cycle wide, once per press.
  - Release generates nothing. There is no debounce; bounce yields multiple presses.
- **Event priority.** When several pulses coincide, only the highest-priority event *legal in the current state* is acted on. Priority is clear > start > lap; the others are dropped.
- **States** (2-bit):
  - IDLE: count 0, stopped.
  - RUN: counting, display live.
  - LAP: counting, display frozen.
  - STOP: halted, display live.
- **Transitions:**
  - IDLE: start→RUN. Clear→IDLE (no-op). Lap ignored.
  - RUN: start→STOP. Lap→LAP, latching the current count into the lap register. Clear ignored.
  - LAP: lap→RUN. Start→STOP. Clear ignored.
  - STOP: start→RUN. Clear→IDLE, with count=0, prescaler=0 and OVERFLOW=0. Lap ignored.
- **Prescaler.**
  - Counts 0..`TICK_DIV`-1 while the state is RUN or LAP.
  - `tick` is asserted when the prescaler equals `TICK_DIV`-1; the prescaler then returns to 0.
  - Holds its value in STOP, so resume continues the partial interval.
  - Zeroed in IDLE.
- **BCD counter.**
  - Increments on an edge where the pre-edge state is RUN or LAP and `tick`=1.
  - Ripple carry between digits: each digit goes 9→0 with carry into the next.
  - 99.99 + 1 → 00.00 and sets OVERFLOW. Counting continues.
  - No binary intermediate: every digit register only ever holds 0–9.
- **Display.** `DIGITS` = lap register in LAP, otherwise the live count. It is a combinational mux of registered values, with no extra latency.
- **Tick on exit.** A tick coinciding with an exit from RUN/LAP (e.g. a start event moving to STOP) still increments on that edge.

## Timing
- **Reset values:**
  - State IDLE.
  - Count, lap register and prescaler 0.
  - Synchroniser and history registers 1 (keys released).
  - Outputs: `DIGITS`=16'h0000, `RUNNING`=0, `LAP_ACTIVE`=0, `OVERFLOW`=0.
- **Reset mid-operation** returns the block to the reset values immediately, regardless of state.
- **Command latency.** With KEY sampled low first at edge N:
  - `s2` goes low at N+1, and the pulse is high during cycle N+1.
  - The state and outputs change at edge N+2.
- **First increment** after start from IDLE happens `TICK_DIV` edges after the state enters RUN.
- **Lap latch** captures the count value present at the transition edge, including any increment on that same edge.

## Test plan
All scenarios use `TICK_DIV`=4.
- **Reset:** assert `RESET` mid-RUN with count 12.34 → all outputs 0 asynchronously; after release, state is IDLE and nothing counts.
- **Start and count:** press `KEY[0]` in IDLE, hold 10 cycles → `RUNNING`=1 two edges after the first low sample; after 40 more edges `DIGITS`=16'h0010.
- **Carry chain and wrap:** run 9999 ticks → `DIGITS`=16'h9999, `OVERFLOW`=0; one more tick → 16'h0000, `OVERFLOW`=1 and remains set while counting continues.
- **Lap:**
  - Press lap at count 0005 → `LAP_ACTIVE`=1 and `DIGITS` frozen at 0005 while the internal count advances.
  - After 20 ticks, press lap again → `DIGITS`=0025.
- **Stop, resume, clear:**
  - Stop with prescaler at 2 → count holds.
  - Resume → next increment after 2 edges.
  - Stop, then clear → `DIGITS`=0 and `OVERFLOW`=0.
  - Clear pressed while in RUN → ignored.
- **Simultaneous events:**
  - `KEY[0]`, `KEY[1]` and `KEY[2]` pressed on the same cycle in RUN → STOP, no lap latch.
  - The same three keys pressed in STOP → IDLE, count cleared.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Pushbutton inputs and display/status outputs of the BCD stopwatch.
interface stopwatch_bcd_if;
   logic [2:0]  KEY;
   logic [15:0] DIGITS;
   logic        RUNNING;
   logic        LAP_ACTIVE;
   logic        OVERFLOW;

   modport master (
      output KEY,
      input  DIGITS, RUNNING, LAP_ACTIVE, OVERFLOW
   );

   modport slave (
      input  KEY,
      output DIGITS, RUNNING, LAP_ACTIVE, OVERFLOW
   );
endinterface

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (SS.hh) with start/stop, lap freeze and clear,
// driven by synchronised active-low pushbuttons.
module stopwatch_bcd #(
   parameter int unsigned TICK_DIV = 500000
) (
   input  logic            CLOCK_50,
   input  logic            RESET,
   stopwatch_bcd_if.slave  sw
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_LAP  = 2'd2,
      S_STOP = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    key_s1_q, key_s1_d;
   logic [2:0]    key_s2_q, key_s2_d;
   logic [2:0]    key_p_q, key_p_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   count_q, count_d;
   logic [15:0]   lap_q, lap_d;
   logic          overflow_q, overflow_d;
   logic          running_q, running_d;
   logic          lap_active_q, lap_active_d;

   logic [2:0]    key_press;
   logic          ev_start, ev_lap, ev_clear;
   logic          counting, tick;
   logic [15:0]   count_inc;
   logic          wrap;

   // Press pulse is the released-to-pressed transition seen after synchronisation.
   assign key_press = key_p_q & ~key_s2_q;
   assign ev_start  = key_press[0];
   assign ev_lap    = key_press[1];
   assign ev_clear  = key_press[2];

   assign counting  = (state_q == S_RUN) || (state_q == S_LAP);
   assign tick      = counting && (presc_q == PRESC_LAST);

   // Digit-wise BCD increment with ripple carry; carry out of the top digit is the wrap.
   always_comb begin
      logic carry;
      count_inc = count_q;
      carry     = tick;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (count_q[i*4 +: 4] == 4'd9) begin
               count_inc[i*4 +: 4] = 4'd0;
            end else begin
               count_inc[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   always_comb begin
      state_d    = state_q;
      key_s1_d   = sw.KEY;
      key_s2_d   = key_s1_q;
      key_p_d    = key_s2_q;
      count_d    = count_inc;
      lap_d      = lap_q;
      overflow_d = overflow_q | wrap;
      presc_d    = presc_q;

      if (counting) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end

      // Only the highest-priority event legal in the current state is taken.
      case (state_q)
         S_IDLE: begin
            if (!ev_clear && ev_start) state_d = S_RUN;
         end
         S_RUN: begin
            if (ev_start) begin
               state_d = S_STOP;
            end else if (ev_lap) begin
               state_d = S_LAP;
               lap_d   = count_inc;
            end
         end
         S_LAP: begin
            if (ev_start)    state_d = S_STOP;
            else if (ev_lap) state_d = S_RUN;
         end
         S_STOP: begin
            if (ev_clear) begin
               state_d    = S_IDLE;
               count_d    = '0;
               overflow_d = 1'b0;
            end else if (ev_start) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) presc_d = '0;

      running_d    = (state_d == S_RUN) || (state_d == S_LAP);
      lap_active_d = (state_d == S_LAP);
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         key_s1_q     <= 3'b111;
         key_s2_q     <= 3'b111;
         key_p_q      <= 3'b111;
         presc_q      <= '0;
         count_q      <= '0;
         lap_q        <= '0;
         overflow_q   <= 1'b0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_s1_q     <= key_s1_d;
         key_s2_q     <= key_s2_d;
         key_p_q      <= key_p_d;
         presc_q      <= presc_d;
         count_q      <= count_d;
         lap_q        <= lap_d;
         overflow_q   <= overflow_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
      end
   end

   // Display is frozen on the lap register while in LAP.
   assign sw.DIGITS     = (state_q == S_LAP) ? lap_q : count_q;
   assign sw.RUNNING    = running_q;
   assign sw.LAP_ACTIVE = lap_active_q;
   assign sw.OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed vector table, hand-written corner sequences,
// and random key activity checked every cycle against a centisecond-level model.
module tb_stopwatch_bcd;

   localparam int unsigned TD = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

   logic CLOCK_50 = 1'b0;
   logic RESET;

   stopwatch_bcd_if sw ();

   stopwatch_bcd #(.TICK_DIV(TD)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .sw       (sw)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  keys;
      int          cycles;
      logic [15:0] digits;
      logic        run;
      logic        lap;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   // Model: time as an integer number of centiseconds, mode per the four states.
   int         m_mode;
   int         m_cs;
   int         m_presc;
   int         m_lap;
   logic       m_ovf;
   logic [2:0] kh1, kh2, kh3;
   logic       mon_en = 1'b0;

   function automatic logic [15:0] bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [18:0] obs();
      return {sw.DIGITS, sw.RUNNING, sw.LAP_ACTIVE, sw.OVERFLOW};
   endfunction

   function automatic logic [18:0] model_obs();
      logic run;
      run = (m_mode == M_RUN) || (m_mode == M_LAP);
      return {bcd(m_mode == M_LAP ? m_lap : m_cs), run, logic'(m_mode == M_LAP), m_ovf};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got digits=%h run=%b lap=%b ovf=%b, expected digits=%h run=%b lap=%b ovf=%b",
                  name, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_cs    = 0;
      m_presc = 0;
      m_lap   = 0;
      m_ovf   = 1'b0;
      kh1     = 3'b111;
      kh2     = 3'b111;
      kh3     = 3'b111;
   endtask

   task automatic model_step(input logic [2:0] k);
      logic [2:0] fall;
      logic       counting, tick;
      // A press first sampled two edges ago takes effect on this edge.
      fall     = ~kh2 & kh3;
      counting = (m_mode == M_RUN) || (m_mode == M_LAP);
      tick     = counting && (m_presc == int'(TD) - 1);
      if (tick) begin
         m_cs = m_cs + 1;
         if (m_cs == 10000) begin
            m_cs  = 0;
            m_ovf = 1'b1;
         end
      end
      if (counting) m_presc = tick ? 0 : m_presc + 1;
      case (m_mode)
         M_IDLE: if (!fall[2] && fall[0]) m_mode = M_RUN;
         M_RUN: begin
            if (fall[0]) m_mode = M_STOP;
            else if (fall[1]) begin
               m_mode = M_LAP;
               m_lap  = m_cs;
            end
         end
         M_LAP: begin
            if (fall[0])      m_mode = M_STOP;
            else if (fall[1]) m_mode = M_RUN;
         end
         default: begin
            if (fall[2]) begin
               m_mode  = M_IDLE;
               m_cs    = 0;
               m_presc = 0;
               m_ovf   = 1'b0;
            end else if (fall[0]) begin
               m_mode = M_RUN;
            end
         end
      endcase
      kh3 = kh2;
      kh2 = kh1;
      kh1 = k;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLOCK_50 or posedge RESET);
         if (RESET) model_reset();
         else       model_step(sw.KEY);
      end
   end

   initial begin
      forever begin
         @(negedge CLOCK_50);
         if (mon_en && !RESET) check("model", obs(), model_obs());
      end
   end

   function automatic void add(input logic [2:0] k, input int n, input logic [15:0] d,
                               input logic r, input logic l, input logic o);
      vec_t v;
      v.keys = k; v.cycles = n; v.digits = d; v.run = r; v.lap = l; v.ovf = o;
      vecs.push_back(v);
   endfunction

   task automatic wait_count(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (!(m_cs == target && m_mode == M_RUN) && n < budget) begin
         @(negedge CLOCK_50);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: count %0d not reached within %0d cycles (model at %0d)",
                  name, target, budget, m_cs);
      end
   endtask

   task automatic press(input logic [2:0] k);
      sw.KEY = k;
      @(negedge CLOCK_50);
      sw.KEY = 3'b111;
   endtask

   initial begin
      // Start, count, lap, stop/resume, ignored clear, clear, simultaneous keys.
      add(3'b110,  1, 16'h0000, 0, 0, 0);
      add(3'b111,  1, 16'h0000, 0, 0, 0);
      add(3'b111,  1, 16'h0000, 1, 0, 0);
      add(3'b111,  3, 16'h0000, 1, 0, 0);
      add(3'b111,  1, 16'h0001, 1, 0, 0);
      add(3'b111, 36, 16'h0010, 1, 0, 0);
      add(3'b101,  1, 16'h0010, 1, 0, 0);
      add(3'b111,  2, 16'h0010, 1, 1, 0);
      add(3'b111,  8, 16'h0010, 1, 1, 0);
      add(3'b101,  1, 16'h0010, 1, 1, 0);
      add(3'b111,  2, 16'h0013, 1, 0, 0);
      add(3'b110,  1, 16'h0013, 1, 0, 0);
      add(3'b111,  2, 16'h0014, 0, 0, 0);
      add(3'b111, 10, 16'h0014, 0, 0, 0);
      add(3'b110,  1, 16'h0014, 0, 0, 0);
      add(3'b111,  2, 16'h0014, 1, 0, 0);
      add(3'b111,  2, 16'h0014, 1, 0, 0);
      add(3'b111,  1, 16'h0015, 1, 0, 0);
      add(3'b011,  1, 16'h0015, 1, 0, 0);
      add(3'b111,  3, 16'h0016, 1, 0, 0);
      add(3'b110,  1, 16'h0016, 1, 0, 0);
      add(3'b111,  2, 16'h0016, 0, 0, 0);
      add(3'b011,  1, 16'h0016, 0, 0, 0);
      add(3'b111,  2, 16'h0000, 0, 0, 0);
      add(3'b110,  1, 16'h0000, 0, 0, 0);
      add(3'b111,  2, 16'h0000, 1, 0, 0);
      add(3'b111,  8, 16'h0002, 1, 0, 0);
      add(3'b000,  1, 16'h0002, 1, 0, 0);
      add(3'b111,  2, 16'h0002, 0, 0, 0);
      add(3'b111,  5, 16'h0002, 0, 0, 0);
      add(3'b000,  1, 16'h0002, 0, 0, 0);
      add(3'b111,  2, 16'h0000, 0, 0, 0);

      RESET  = 1'b1;
      sw.KEY = 3'b111;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("reset_values", obs(), 19'h0);
      RESET  = 1'b0;
      mon_en = 1'b1;

      foreach (vecs[i]) begin
         sw.KEY = vecs[i].keys;
         repeat (vecs[i].cycles) @(posedge CLOCK_50);
         @(negedge CLOCK_50);
         check($sformatf("vec%0d", i), obs(),
               {vecs[i].digits, vecs[i].run, vecs[i].lap, vecs[i].ovf});
      end

      // Asynchronous reset while running at 12.34.
      press(3'b110);
      wait_count(1234, 6000, "reach_1234");
      check("at_1234", obs(), {16'h1234, 1'b1, 1'b0, 1'b0});
      #2 RESET = 1'b1;
      #1 check("async_reset", obs(), 19'h0);
      @(negedge CLOCK_50);
      RESET = 1'b0;
      repeat (20) @(negedge CLOCK_50);
      check("idle_after_reset", obs(), 19'h0);

      // Full carry chain and wrap with sticky overflow.
      press(3'b110);
      wait_count(9999, 41000, "reach_9999");
      check("at_9999", obs(), {16'h9999, 1'b1, 1'b0, 1'b0});
      repeat (TD) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("wrap", obs(), {16'h0000, 1'b1, 1'b0, 1'b1});
      repeat (40) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("ovf_sticky", obs(), {16'h0010, 1'b1, 1'b0, 1'b1});

      // Random key activity, including bounce-like toggling and coincident presses.
      for (int c = 0; c < 3000; c++) begin
         logic [2:0] k;
         k = sw.KEY;
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 9) == 0) k[b] = ~k[b];
         end
         sw.KEY = k;
         @(negedge CLOCK_50);
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
